// File: rtl/spi_packet_assembler.sv
`default_nettype none
// ============================================================================
// Module      : spi_packet_assembler
// Description : Builds one packet from a stream of received SPI bytes.
//               Byte format: one metadata byte, then 8 prefix bytes, then
//               (metadata - 8) payload bytes (0..32). The finished packet is
//               held stable on the packet_* outputs until the downstream side
//               accepts it with packet_ready.
//
// Parameters  : TIMEOUT_CYCLES   idle clk cycles allowed between bytes of one
//                                packet (used only in the timeout build)
//
// Ports       : clk              sole clock, rising edge
//               rst              asynchronous reset, active low
//               RX_valid         one-cycle strobe, rx_byte is valid
//               rx_byte[7:0]     received byte
//               packet_ready     downstream accepts the held packet
//               packet_valid     assembled packet available
//               packet_meta_data metadata byte of the packet
//               packet_prefix    64-bit name prefix, first byte in [63:56]
//               packet_data      256-bit payload, left aligned, zero filled
//               packet_error     one-cycle pulse, bad metadata or timeout
//               overflow         one-cycle pulse, byte dropped while held
//               busy             high whenever the FSM is not IDLE
//
// Build macro : SPI_ASM_TIMEOUT_EN  enables the inter-byte timeout; when
//               undefined the assembler waits indefinitely for each byte.
//
// Revision    : 1.0  initial release
// ============================================================================
module spi_packet_assembler #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         RX_valid,
   input  logic [7:0]   rx_byte,
   input  logic         packet_ready,
   output logic         packet_valid,
   output logic [7:0]   packet_meta_data,
   output logic [63:0]  packet_prefix,
   output logic [255:0] packet_data,
   output logic         packet_error,
   output logic         overflow,
   output logic         busy
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PREFIX = 2'd1,
      S_DATA   = 2'd2,
      S_HOLD   = 2'd3
   } state_t;

   state_t      state;
   logic [5:0]  byte_cnt;

   logic        meta_ok;
   logic        take_meta;
   logic        data_last;
   logic [7:0]  data_slot_lsb;
   logic        timeout_hit;

   // A zero-cycle budget makes no sense; reject it at elaboration.
   if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_check
      $error("spi_packet_assembler: TIMEOUT_CYCLES must be >= 1");
   end

   // Legal metadata covers 8 prefix bytes plus 0..32 payload bytes.
   assign meta_ok = (rx_byte >= 8'd8) && (rx_byte <= 8'd40);

   // A byte is metadata when idle, or when it arrives in the very cycle the
   // held packet is handed off.
   assign take_meta = RX_valid &&
                      ((state == S_IDLE) || ((state == S_HOLD) && packet_ready));

   // Payload byte n is the last one when n + 1 == meta - 8.
   assign data_last = (({2'b00, byte_cnt} + 8'd9) == packet_meta_data);

   // Payload byte n lands at bit offset 8*(31-n); 31-n on 5 bits is ~n.
   assign data_slot_lsb = {~byte_cnt[4:0], 3'b000};

`ifdef SPI_ASM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [TW-1:0] idle_cnt;
   logic          assembling;

   assign assembling  = (state == S_PREFIX) || (state == S_DATA);

   // Fires on the TIMEOUT_CYCLES-th consecutive cycle without a byte.
   assign timeout_hit = assembling && !RX_valid &&
                        (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idle_cnt <= '0;
      end else if (assembling && !RX_valid && !timeout_hit) begin
         idle_cnt <= idle_cnt + 1'b1;
      end else begin
         idle_cnt <= '0;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= S_IDLE;
         byte_cnt         <= 6'd0;
         packet_valid     <= 1'b0;
         packet_meta_data <= 8'd0;
         packet_prefix    <= 64'd0;
         packet_data      <= 256'd0;
         packet_error     <= 1'b0;
         overflow         <= 1'b0;
         busy             <= 1'b0;
      end else begin
         packet_error <= 1'b0;
         overflow     <= 1'b0;

         if (take_meta) begin
            packet_meta_data <= rx_byte;
            byte_cnt         <= 6'd0;
            packet_valid     <= 1'b0;
            if (meta_ok) begin
               state         <= S_PREFIX;
               busy          <= 1'b1;
               // Start from a clean slate so no bytes of an earlier packet
               // remain visible in the unfilled payload slots.
               packet_prefix <= 64'd0;
               packet_data   <= 256'd0;
            end else begin
               state        <= S_IDLE;
               busy         <= 1'b0;
               packet_error <= 1'b1;
            end
         end else begin
            case (state)
               S_IDLE: begin
                  busy <= 1'b0;
               end

               S_PREFIX: begin
                  if (timeout_hit) begin
                     state         <= S_IDLE;
                     busy          <= 1'b0;
                     byte_cnt      <= 6'd0;
                     packet_error  <= 1'b1;
                     packet_prefix <= 64'd0;
                     packet_data   <= 256'd0;
                  end else if (RX_valid) begin
                     packet_prefix <= {packet_prefix[55:0], rx_byte};
                     if (byte_cnt == 6'd7) begin
                        byte_cnt <= 6'd0;
                        if (packet_meta_data == 8'd8) begin
                           state        <= S_HOLD;
                           packet_valid <= 1'b1;
                        end else begin
                           state <= S_DATA;
                        end
                     end else begin
                        byte_cnt <= byte_cnt + 6'd1;
                     end
                  end
               end

               S_DATA: begin
                  if (timeout_hit) begin
                     state         <= S_IDLE;
                     busy          <= 1'b0;
                     byte_cnt      <= 6'd0;
                     packet_error  <= 1'b1;
                     packet_prefix <= 64'd0;
                     packet_data   <= 256'd0;
                  end else if (RX_valid) begin
                     packet_data[data_slot_lsb +: 8] <= rx_byte;
                     if (data_last) begin
                        state        <= S_HOLD;
                        byte_cnt     <= 6'd0;
                        packet_valid <= 1'b1;
                     end else begin
                        byte_cnt <= byte_cnt + 6'd1;
                     end
                  end
               end

               S_HOLD: begin
                  if (packet_ready) begin
                     state        <= S_IDLE;
                     busy         <= 1'b0;
                     packet_valid <= 1'b0;
                  end else if (RX_valid) begin
                     // Held packet must stay intact; the byte is lost.
                     overflow <= 1'b1;
                  end
               end

               default: begin
                  state        <= S_IDLE;
                  busy         <= 1'b0;
                  packet_valid <= 1'b0;
                  byte_cnt     <= 6'd0;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_packet_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_packet_assembler
// Description : Directed self-checking bench for spi_packet_assembler.
//               Runs in both the default build and with SPI_ASM_TIMEOUT_EN
//               (TIMEOUT_CYCLES = 16 in that build).
// Revision    : 1.0  initial release
// ============================================================================
module tb_spi_packet_assembler;

`ifdef SPI_ASM_TIMEOUT_EN
   localparam int TO_CYC = 16;
`else
   localparam int TO_CYC = 1024;
`endif

   localparam logic [63:0]  PREFIX_A = 64'd129;
   localparam logic [255:0] DATA_A   = {"here is data", 160'd0};
   localparam logic [63:0]  PREFIX_B = 64'h0102030405060708;
   localparam logic [63:0]  PREFIX_C = 64'h1122334455667788;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         RX_valid = 1'b0;
   logic [7:0]   rx_byte = 8'd0;
   logic         packet_ready = 1'b0;
   logic         packet_valid;
   logic [7:0]   packet_meta_data;
   logic [63:0]  packet_prefix;
   logic [255:0] packet_data;
   logic         packet_error;
   logic         overflow;
   logic         busy;

   int checks = 0;
   int errors = 0;

   spi_packet_assembler #(
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .RX_valid         (RX_valid),
      .rx_byte          (rx_byte),
      .packet_ready     (packet_ready),
      .packet_valid     (packet_valid),
      .packet_meta_data (packet_meta_data),
      .packet_prefix    (packet_prefix),
      .packet_data      (packet_data),
      .packet_error     (packet_error),
      .overflow         (overflow),
      .busy             (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One byte strobe, followed by one idle cycle; returns at the negedge
   // right after the capturing rising edge.
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      RX_valid = 1'b1;
      rx_byte  = b;
      @(negedge clk);
      RX_valid = 1'b0;
      rx_byte  = 8'd0;
   endtask

   task automatic send_prefix(input logic [63:0] p);
      for (int i = 0; i < 8; i++) send_byte(p[63-8*i -: 8]);
   endtask

   task automatic send_data(input logic [255:0] d, input int n);
      for (int i = 0; i < n; i++) send_byte(d[255-8*i -: 8]);
   endtask

   task automatic send_pkt_a(input string tag);
      send_byte(8'h28);
      send_prefix(PREFIX_A);
      send_data(DATA_A, 31);
      check({tag, "_valid_before_last"}, packet_valid, 1'b0);
      send_byte(DATA_A[7:0]);
      check({tag, "_valid_latency"}, packet_valid, 1'b1);
      check({tag, "_meta"},   packet_meta_data, 8'h28);
      check({tag, "_prefix"}, packet_prefix, PREFIX_A);
      check({tag, "_data"},   packet_data, DATA_A);
      check({tag, "_busy"},   busy, 1'b1);
   endtask

   task automatic handoff(input string tag);
      @(negedge clk);
      packet_ready = 1'b1;
      @(negedge clk);
      packet_ready = 1'b0;
      check({tag, "_valid_after_ready"}, packet_valid, 1'b0);
      check({tag, "_busy_after_ready"},  busy, 1'b0);
   endtask

   initial begin
      // ---- asynchronous reset at start ----
      #1 rst = 1'b0;
      #1;
      check("rst_valid",    packet_valid, 1'b0);
      check("rst_meta",     packet_meta_data, 8'd0);
      check("rst_prefix",   packet_prefix, 64'd0);
      check("rst_data",     packet_data, 256'd0);
      check("rst_error",    packet_error, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_busy",     busy, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // ---- full 40-byte packet, held until ready ----
      send_pkt_a("pktA");
      repeat (3) @(negedge clk);
      check("pktA_hold_valid",  packet_valid, 1'b1);
      check("pktA_hold_prefix", packet_prefix, PREFIX_A);
      check("pktA_hold_data",   packet_data, DATA_A);
      handoff("pktA");

      // ---- prefix-only packet, payload must read zero ----
      send_byte(8'h08);
      send_prefix(PREFIX_B);
      check("pkt8_valid",  packet_valid, 1'b1);
      check("pkt8_prefix", packet_prefix, PREFIX_B);
      check("pkt8_data",   packet_data, 256'd0);
      check("pkt8_meta",   packet_meta_data, 8'h08);
      handoff("pkt8");

      // ---- illegal metadata values at both boundaries ----
      send_byte(8'h05);
      check("meta05_error", packet_error, 1'b1);
      check("meta05_busy",  busy, 1'b0);
      check("meta05_meta",  packet_meta_data, 8'h05);
      @(negedge clk);
      check("meta05_error_pulse", packet_error, 1'b0);
      send_byte(8'h29);
      check("meta29_error", packet_error, 1'b1);
      check("meta29_busy",  busy, 1'b0);
      @(negedge clk);
      check("meta29_error_pulse", packet_error, 1'b0);
      send_byte(8'h07);
      check("meta07_error", packet_error, 1'b1);

      // ---- overflow while held, then handoff with simultaneous metadata ----
      send_pkt_a("pktO");
      send_byte(8'hAA);
      check("ovf_pulse",  overflow, 1'b1);
      check("ovf_valid",  packet_valid, 1'b1);
      check("ovf_meta",   packet_meta_data, 8'h28);
      check("ovf_prefix", packet_prefix, PREFIX_A);
      check("ovf_data",   packet_data, DATA_A);
      @(negedge clk);
      check("ovf_pulse_end", overflow, 1'b0);
      RX_valid     = 1'b1;
      rx_byte      = 8'h0C;
      packet_ready = 1'b1;
      @(negedge clk);
      RX_valid     = 1'b0;
      rx_byte      = 8'd0;
      packet_ready = 1'b0;
      check("swap_valid",  packet_valid, 1'b0);
      check("swap_busy",   busy, 1'b1);
      check("swap_meta",   packet_meta_data, 8'h0C);
      check("swap_prefix", packet_prefix, 64'd0);
      check("swap_data",   packet_data, 256'd0);

      // ---- 4-byte payload packet with a 16-cycle stall after byte 3 ----
      send_prefix(PREFIX_C);
      send_byte(8'hD1);
      send_byte(8'hD2);
      send_byte(8'hD3);
      check("stall_busy_before", busy, 1'b1);
      repeat (16) @(negedge clk);
`ifdef SPI_ASM_TIMEOUT_EN
      check("timeout_error", packet_error, 1'b1);
      check("timeout_busy",  busy, 1'b0);
      check("timeout_valid", packet_valid, 1'b0);
      @(negedge clk);
      check("timeout_error_pulse", packet_error, 1'b0);
`else
      check("stall_no_error", packet_error, 1'b0);
      check("stall_busy",     busy, 1'b1);
      send_byte(8'hD4);
      check("stall_valid",  packet_valid, 1'b1);
      check("stall_prefix", packet_prefix, PREFIX_C);
      check("stall_data",   packet_data, {32'hD1D2D3D4, 224'd0});
      check("stall_meta",   packet_meta_data, 8'h0C);
      handoff("stall");
`endif

      // ---- reset in the middle of the prefix ----
      send_byte(8'h28);
      send_byte(8'hA1);
      send_byte(8'hA2);
      send_byte(8'hA3);
      send_byte(8'hA4);
      check("mid_prefix", packet_prefix, 64'h00000000A1A2A3A4);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_busy",   busy, 1'b0);
      check("mid_rst_meta",   packet_meta_data, 8'd0);
      check("mid_rst_prefix", packet_prefix, 64'd0);
      check("mid_rst_valid",  packet_valid, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_error", packet_error, 1'b0);
      check("post_rst_valid", packet_valid, 1'b0);
      check("post_rst_busy",  busy, 1'b0);
      send_pkt_a("pktR");
      handoff("pktR");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
